// File: rtl/dmem_lsu_if.sv
// Load/store unit bus bundle: pipeline request/response plus the dmem command,
// read-return and write-data channels.
interface dmem_lsu_if #(
    parameter int unsigned P_ADDR_BITS = 32,
    parameter int unsigned P_DATA_BITS = 32
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_is_store;
    logic [2:0]                 req_funct3;
    logic [P_ADDR_BITS-1:0]     req_addr;
    logic [P_DATA_BITS-1:0]     req_wdata;

    logic                       rsp_valid;
    logic [P_DATA_BITS-1:0]     rsp_rdata;
    logic [1:0]                 rsp_exc;

    logic [P_ADDR_BITS-1:0]     dmem_addr;
    logic                       dmem_cmd;
    logic [1:0]                 dmem_size;
    logic                       dmem_valid;
    logic                       dmem_ready;

    logic                       dmem_r_valid;
    logic [P_DATA_BITS-1:0]     dmem_r_data;
    logic                       dmem_r_resp;
    logic                       dmem_r_ready;

    logic                       dmem_w_valid;
    logic                       dmem_w_ready;
    logic                       dmem_w_resp;
    logic [P_DATA_BITS/8-1:0]   dmem_w_strb;
    logic [P_DATA_BITS-1:0]     dmem_w_data;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        input  dmem_ready, dmem_r_valid, dmem_r_data, dmem_r_resp, dmem_w_ready, dmem_w_resp,
        output req_ready, rsp_valid, rsp_rdata, rsp_exc,
        output dmem_addr, dmem_cmd, dmem_size, dmem_valid, dmem_r_ready,
        output dmem_w_valid, dmem_w_strb, dmem_w_data
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        output dmem_ready, dmem_r_valid, dmem_r_data, dmem_r_resp, dmem_w_ready, dmem_w_resp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_exc,
        input  dmem_addr, dmem_cmd, dmem_size, dmem_valid, dmem_r_ready,
        input  dmem_w_valid, dmem_w_strb, dmem_w_data
    );
endinterface

// File: rtl/dmem_lsu.sv
// RV32 load/store unit: one outstanding access, size/alignment checks,
// byte-lane steering for stores and sign/zero extension for loads.
module dmem_lsu #(
    parameter int unsigned P_ADDR_BITS = 32,
    parameter int unsigned P_DATA_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    dmem_lsu_if.slave   io_lsu
);
    localparam int unsigned AW = P_ADDR_BITS;
    localparam int unsigned DW = P_DATA_BITS;
    localparam int unsigned SW = DW / 8;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_RWAIT, S_RESP} state_t;
    state_t r_state, w_state_nxt;

    logic           r_is_store;
    logic [2:0]     r_funct3;
    logic [1:0]     r_addr_lo;
    logic           r_cmd_done, r_w_done, r_w_err;

    logic           r_req_ready, r_rsp_valid, r_dmem_cmd, r_dmem_valid;
    logic           r_dmem_r_ready, r_dmem_w_valid;
    logic [DW-1:0]  r_rsp_rdata, r_dmem_w_data;
    logic [1:0]     r_rsp_exc, r_dmem_size;
    logic [AW-1:0]  r_dmem_addr;
    logic [SW-1:0]  r_dmem_w_strb;

    logic           w_req_ready_nxt, w_rsp_valid_nxt, w_dmem_cmd_nxt, w_dmem_valid_nxt;
    logic           w_dmem_r_ready_nxt, w_dmem_w_valid_nxt;
    logic [DW-1:0]  w_rsp_rdata_nxt, w_dmem_w_data_nxt;
    logic [1:0]     w_rsp_exc_nxt, w_dmem_size_nxt;
    logic [AW-1:0]  w_dmem_addr_nxt;
    logic [SW-1:0]  w_dmem_w_strb_nxt;

    logic           w_accept, w_illegal, w_misalign, w_is_store;
    logic           w_cmd_hs, w_w_hs, w_r_hs, w_cmd_done, w_w_done, w_w_err;
    logic [SW-1:0]  w_req_strb;
    logic [DW-1:0]  w_req_data, w_shifted, w_load_data;

    assign w_accept   = io_lsu.req_valid && r_req_ready;
    assign w_illegal  = (io_lsu.req_funct3 == 3'd3) || (io_lsu.req_funct3[2:1] == 2'b11) ||
                        (io_lsu.req_is_store && io_lsu.req_funct3[2]);
    assign w_misalign = ((io_lsu.req_funct3[1:0] == 2'd1) && io_lsu.req_addr[0]) ||
                        ((io_lsu.req_funct3[1:0] == 2'd2) && (io_lsu.req_addr[1:0] != 2'b00));
    assign w_is_store = (r_state == S_IDLE) ? io_lsu.req_is_store : r_is_store;

    // Handshakes; the sticky flags let command and write data complete in different cycles
    assign w_cmd_hs   = r_dmem_valid && io_lsu.dmem_ready;
    assign w_w_hs     = r_dmem_w_valid && io_lsu.dmem_w_ready;
    assign w_r_hs     = r_dmem_r_ready && io_lsu.dmem_r_valid;
    assign w_cmd_done = r_cmd_done || w_cmd_hs;
    assign w_w_done   = r_w_done || w_w_hs;
    assign w_w_err    = r_w_err || (w_w_hs && io_lsu.dmem_w_resp);

    always_comb begin : store_lanes
        w_req_strb = SW'(4'b1111);
        w_req_data = io_lsu.req_wdata;
        case (io_lsu.req_funct3[1:0])
            2'd0: begin
                w_req_strb = SW'(4'b0001) << io_lsu.req_addr[1:0];
                w_req_data = {4{io_lsu.req_wdata[7:0]}};
            end
            2'd1: begin
                w_req_strb = SW'(4'b0011) << io_lsu.req_addr[1:0];
                w_req_data = {2{io_lsu.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin : load_extract
        w_shifted   = io_lsu.dmem_r_data >> {r_addr_lo, 3'b000};
        w_load_data = w_shifted;
        case (r_funct3)
            3'd0:    w_load_data = {{(DW-8){w_shifted[7]}}, w_shifted[7:0]};
            3'd4:    w_load_data = {{(DW-8){1'b0}}, w_shifted[7:0]};
            3'd1:    w_load_data = {{(DW-16){w_shifted[15]}}, w_shifted[15:0]};
            3'd5:    w_load_data = {{(DW-16){1'b0}}, w_shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin : state_reg
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin : next_state
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = (w_illegal || w_misalign) ? S_RESP : S_CMD;
            S_CMD: begin
                if (r_is_store) begin
                    if (w_cmd_done && w_w_done) w_state_nxt = S_RESP;
                end else if (w_cmd_hs) begin
                    w_state_nxt = w_r_hs ? S_RESP : S_RWAIT;
                end
            end
            S_RWAIT: if (w_r_hs) w_state_nxt = S_RESP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin : output_logic
        w_req_ready_nxt    = (w_state_nxt == S_IDLE);
        w_rsp_valid_nxt    = (w_state_nxt == S_RESP);
        w_rsp_rdata_nxt    = '0;
        w_rsp_exc_nxt      = 2'd0;
        w_dmem_valid_nxt   = (w_state_nxt == S_CMD) && !((r_state == S_CMD) && w_cmd_done);
        w_dmem_w_valid_nxt = (w_state_nxt == S_CMD) && w_is_store && !((r_state == S_CMD) && w_w_done);
        w_dmem_r_ready_nxt = ((w_state_nxt == S_CMD) && !w_is_store) || (w_state_nxt == S_RWAIT);
        w_dmem_addr_nxt    = r_dmem_addr;
        w_dmem_cmd_nxt     = r_dmem_cmd;
        w_dmem_size_nxt    = r_dmem_size;
        w_dmem_w_data_nxt  = r_dmem_w_data;
        w_dmem_w_strb_nxt  = (w_state_nxt == S_CMD) ? r_dmem_w_strb : '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_rsp_exc_nxt = 2'd2;
                    end else if (w_misalign) begin
                        w_rsp_exc_nxt = 2'd1;
                    end else begin
                        w_dmem_addr_nxt   = {io_lsu.req_addr[AW-1:2], 2'b00};
                        w_dmem_cmd_nxt    = io_lsu.req_is_store;
                        w_dmem_size_nxt   = io_lsu.req_funct3[1:0];
                        w_dmem_w_strb_nxt = io_lsu.req_is_store ? w_req_strb : '0;
                        w_dmem_w_data_nxt = w_req_data;
                    end
                end
            end
            S_CMD, S_RWAIT: begin
                if (w_state_nxt == S_RESP) begin
                    if (r_is_store) begin
                        w_rsp_exc_nxt = w_w_err ? 2'd3 : 2'd0;
                    end else begin
                        w_rsp_exc_nxt   = io_lsu.dmem_r_resp ? 2'd3 : 2'd0;
                        w_rsp_rdata_nxt = io_lsu.dmem_r_resp ? '0 : w_load_data;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin : out_regs
        if (!rst) begin
            r_req_ready    <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_exc      <= 2'd0;
            r_dmem_addr    <= '0;
            r_dmem_cmd     <= 1'b0;
            r_dmem_size    <= 2'd0;
            r_dmem_valid   <= 1'b0;
            r_dmem_r_ready <= 1'b0;
            r_dmem_w_valid <= 1'b0;
            r_dmem_w_strb  <= '0;
            r_dmem_w_data  <= '0;
            r_is_store     <= 1'b0;
            r_funct3       <= 3'd0;
            r_addr_lo      <= 2'd0;
            r_cmd_done     <= 1'b0;
            r_w_done       <= 1'b0;
            r_w_err        <= 1'b0;
        end else begin
            r_req_ready    <= w_req_ready_nxt;
            r_rsp_valid    <= w_rsp_valid_nxt;
            r_rsp_rdata    <= w_rsp_rdata_nxt;
            r_rsp_exc      <= w_rsp_exc_nxt;
            r_dmem_addr    <= w_dmem_addr_nxt;
            r_dmem_cmd     <= w_dmem_cmd_nxt;
            r_dmem_size    <= w_dmem_size_nxt;
            r_dmem_valid   <= w_dmem_valid_nxt;
            r_dmem_r_ready <= w_dmem_r_ready_nxt;
            r_dmem_w_valid <= w_dmem_w_valid_nxt;
            r_dmem_w_strb  <= w_dmem_w_strb_nxt;
            r_dmem_w_data  <= w_dmem_w_data_nxt;
            if (w_accept) begin
                r_is_store <= io_lsu.req_is_store;
                r_funct3   <= io_lsu.req_funct3;
                r_addr_lo  <= io_lsu.req_addr[1:0];
            end
            r_cmd_done <= (r_state == S_CMD) ? w_cmd_done : 1'b0;
            r_w_done   <= (r_state == S_CMD) ? w_w_done   : 1'b0;
            r_w_err    <= (r_state == S_CMD) ? w_w_err    : 1'b0;
        end
    end

    assign io_lsu.req_ready    = r_req_ready;
    assign io_lsu.rsp_valid    = r_rsp_valid;
    assign io_lsu.rsp_rdata    = r_rsp_rdata;
    assign io_lsu.rsp_exc      = r_rsp_exc;
    assign io_lsu.dmem_addr    = r_dmem_addr;
    assign io_lsu.dmem_cmd     = r_dmem_cmd;
    assign io_lsu.dmem_size    = r_dmem_size;
    assign io_lsu.dmem_valid   = r_dmem_valid;
    assign io_lsu.dmem_r_ready = r_dmem_r_ready;
    assign io_lsu.dmem_w_valid = r_dmem_w_valid;
    assign io_lsu.dmem_w_strb  = r_dmem_w_strb;
    assign io_lsu.dmem_w_data  = r_dmem_w_data;
endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 P_ADDR_BITS, default 32, byte-address width.
REQ-002 P_DATA_BITS, default 32, data width; the only supported value is 32.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  pipeline load/store request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_is_store  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RV32 size code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-009 req_addr  in  P_ADDR_BITS  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 rsp_valid  out  1  one-cycle completion pulse; not back-pressured.
REQ-012 rsp_rdata  out  32  extended load result; 0 for stores and exceptions.
REQ-013 rsp_exc  out  2  exception code: 0 none, 1 misaligned, 2 illegal size, 3 bus error.
REQ-014 dmem_addr  out  P_ADDR_BITS  word-aligned address, {addr[31:2],2'b00}.
REQ-015 dmem_cmd  out  1  0 read, 1 write.
REQ-016 dmem_size  out  2  req_funct3[1:0].
REQ-017 dmem_valid  out  1  command valid.
REQ-018 dmem_ready  in  1  command accepted.
REQ-019 dmem_r_valid / dmem_r_data / dmem_r_resp  in  1/32/1  read return; resp 1 = error.
REQ-020 dmem_r_ready  out  1  read data accepted.
REQ-021 dmem_w_valid  out  1  write data valid.
REQ-022 dmem_w_ready / dmem_w_resp  in  1/1  write data accepted / write error.
REQ-023 dmem_w_strb / dmem_w_data  out  4/32  byte strobes / lane-replicated data.

Function
REQ-024 FSM states: IDLE, CMD, RWAIT, RESP. req_ready SHALL be 1 only in IDLE.
REQ-025 Accept when req_valid && req_ready: register all req_* fields.
REQ-026 At accept, check the request in this priority order:
- funct3 in {3,6,7}, or store with funct3 4/5: go to RESP with rsp_exc=2.
- H/HU with addr[0]=1, or W with addr[1:0]!=0: go to RESP with rsp_exc=1.
- In both cases, issue no dmem command.
REQ-027 A legal request SHALL go to CMD. In CMD:
- dmem_valid=1.
- address, cmd, size, strb and data held stable until the dmem_valid && dmem_ready handshake.
REQ-028 Store in CMD:
- dmem_w_valid=1 together with dmem_valid.
- Completion = both handshakes seen; they may occur in different cycles, and each is tracked with a sticky flag.
- On completion go to RESP; rsp_exc=3 if dmem_w_resp=1.
REQ-029 Store strobes:
- B: 4'b0001<<addr[1:0].
- H: 4'b0011<<addr[1:0].
- W: 4'b1111.
REQ-030 Store data: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
REQ-031 Load read-ready and command path:
- dmem_r_ready=1 in CMD and in RWAIT for loads.
- If r_valid && r_ready coincides with the command handshake, go directly to RESP.
- Otherwise, after the command handshake, go to RWAIT and stay there until r_valid.
REQ-032 Load extract: data = r_data >> (8*addr[1:0]).
- B: sign-extend bit 7. BU: zero-extend.
- H: sign-extend bit 15. HU: zero-extend.
- W: unmodified.
- rsp_exc=3 and rsp_rdata=0 if r_resp=1.
REQ-033 RESP lasts one cycle:
- rsp_valid=1 with registered rsp_rdata/rsp_exc.
- Next state is IDLE.
REQ-034 Minimum latency from accept cycle T:
- store: rsp_valid at T+2;
- load with registered return: rsp_valid at T+3;
- exception: rsp_valid at T+1.
REQ-035 r_valid arriving in IDLE or RESP SHALL be ignored (r_ready=0); dmem_w_valid=0 for loads.
REQ-036 Throughput: one outstanding request; a new request is accepted at the earliest in the cycle after RESP.

Reset
REQ-037 While rst=0, the following SHALL hold:
- state=IDLE; sticky flags cleared; all registers 0.
- rsp_valid=0, rsp_exc=0, rsp_rdata=0.
- dmem_valid=0, dmem_w_valid=0, dmem_r_ready=0, dmem_w_strb=0.
- req_ready=0.
REQ-038 Reset mid-transaction SHALL abandon it with no rsp_valid; after rst deasserts, req_ready=1 on the first clk edge.

Verification
REQ-039 SB addr=0x103, wdata=0x000000A5, dmem_ready=w_ready=1 -> dmem_addr=0x100, strb=4'b1000, data=0xA5A5A5A5; rsp_valid at T+2, exc=0.
REQ-040 LH addr=0x202, r_data=0x8001_1234 one cycle after the command -> rsp_rdata=0xFFFF8001; LHU same -> 0x00008001; LB addr=0x201 -> 0x00000012.
REQ-041 LW addr=0x102 -> rsp_exc=1 at T+1, no dmem_valid; funct3=3 -> rsp_exc=2; SB with funct3=4 -> rsp_exc=2.
REQ-042 SW with dmem_ready held low 3 cycles, w_ready high at first CMD cycle -> single completion, rsp_valid once, commands stable throughout.
REQ-043 Load with r_resp=1 -> rsp_exc=3, rsp_rdata=0; LW with r_valid in the handshake cycle -> rsp_valid at T+2.
REQ-044 rst low while in RWAIT -> all outputs 0 at once; no rsp_valid; a subsequent LW completes normally.
